mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/cpu_pkg.sv | 15 +
 rtl/mem_bus_ctrl.sv | 101 ++++++++++
 tb/tb_mem_bus_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared by the CPU-side blocks: default bus widths and the
// state encoding of the memory bus controller.
package cpu_pkg;

   localparam int CPU_DATA_WIDTH = 8;
   localparam int CPU_ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_END    = 2'd3
   } bus_state_t;

endpackage

// File: rtl/mem_bus_ctrl.sv
// CPU-to-SRAM bus controller: IDLE -> SETUP -> ACCESS (1+WAIT_STATES) -> END,
// driving chip select, read/write strobes and a shared tri-state data bus.
module mem_bus_ctrl
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH  = CPU_DATA_WIDTH,
   parameter int ADDR_WIDTH  = CPU_ADDR_WIDTH,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic                  wr,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ack,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_re,
   inout  wire  [DATA_WIDTH-1:0] ram_data,
   output bus_state_t            state_dbg
);

   // Handshake: req/wr/addr/wdata are sampled only in IDLE; once accepted,
   // busy stays high until the FSM is back in IDLE, and ack pulses for exactly
   // one cycle (END) when the transaction completes. No backpressure on ack.

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

   bus_state_t            state;
   logic                  wr_q;
   logic                  drive_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [3:0]            wait_cnt;

   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

   // Only a write owns the bus, from SETUP through END (hold time included).
   assign ram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         wr_q     <= 1'b0;
         drive_q  <= 1'b0;
         wdata_q  <= '0;
         wait_cnt <= '0;
         rdata    <= '0;
         ack      <= 1'b0;
         ram_addr <= '0;
         ram_cs   <= 1'b0;
         ram_we   <= 1'b0;
         ram_re   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  state    <= ST_SETUP;
                  wr_q     <= wr;
                  wdata_q  <= wdata;
                  ram_addr <= addr;
                  ram_cs   <= 1'b1;
                  ram_re   <= ~wr;
                  drive_q  <= wr;
               end
            end
            ST_SETUP: begin
               state    <= ST_ACCESS;
               wait_cnt <= '0;
               ram_we   <= wr_q;
               ram_re   <= ~wr_q;
            end
            ST_ACCESS: begin
               if (wait_cnt == WAIT_LAST) begin
                  state  <= ST_END;
                  ram_we <= 1'b0;
                  ram_re <= 1'b0;
                  ack    <= 1'b1;
                  if (!wr_q) rdata <= ram_data;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            ST_END: begin
               // Always pass through IDLE so the bus is released between transactions.
               state    <= ST_IDLE;
               ack      <= 1'b0;
               ram_cs   <= 1'b0;
               drive_q  <= 1'b0;
               wait_cnt <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: one instance with no wait states, one with three,
// each attached to a simple SRAM model and checked against a reference memory.
module tb_mem_bus_ctrl;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_s[2];
   logic       wr_s[2];
   logic [7:0] addr_s[2];
   logic [7:0] wdata_s[2];
   logic [7:0] rdata_s[2];
   logic [7:0] raddr_s[2];
   logic       ack_s[2], busy_s[2], cs_s[2], we_s[2], re_s[2];
   bus_state_t st_s[2];
   wire  [7:0] bus0, bus1;

   logic [7:0] mem0[256] = '{default: 8'h00};
   logic [7:0] mem1[256] = '{default: 8'h00};
   logic [7:0] ref_mem[2][256] = '{default: '{default: 8'h00}};

   int n_vec = 0;
   int n_err = 0;
   int overlap_cnt = 0;
   int idle_ctrl_cnt = 0;

   always #5 clk = ~clk;

   mem_bus_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst_n(rst_n), .req(req_s[0]), .wr(wr_s[0]), .addr(addr_s[0]),
      .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ack(ack_s[0]), .busy(busy_s[0]),
      .ram_addr(raddr_s[0]), .ram_cs(cs_s[0]), .ram_we(we_s[0]), .ram_re(re_s[0]),
      .ram_data(bus0), .state_dbg(st_s[0])
   );

   mem_bus_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst_n(rst_n), .req(req_s[1]), .wr(wr_s[1]), .addr(addr_s[1]),
      .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ack(ack_s[1]), .busy(busy_s[1]),
      .ram_addr(raddr_s[1]), .ram_cs(cs_s[1]), .ram_we(we_s[1]), .ram_re(re_s[1]),
      .ram_data(bus1), .state_dbg(st_s[1])
   );

   // SRAM models: drive the bus while read-enabled, store on a write-enabled edge.
   assign bus0 = (cs_s[0] && re_s[0]) ? mem0[raddr_s[0]] : 8'hzz;
   assign bus1 = (cs_s[1] && re_s[1]) ? mem1[raddr_s[1]] : 8'hzz;

   always @(posedge clk) begin
      if (cs_s[0] && we_s[0]) mem0[raddr_s[0]] <= bus0;
      if (cs_s[1] && we_s[1]) mem1[raddr_s[1]] <= bus1;
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (we_s[i] && re_s[i]) overlap_cnt++;
         if (!busy_s[i] && (cs_s[i] || we_s[i] || re_s[i] || ack_s[i])) idle_ctrl_cnt++;
      end
   end

   function automatic logic [7:0] bus_of(input int inst);
      return (inst == 0) ? bus0 : bus1;
   endfunction

   // A released bus reads all-Z, or zero under two-state net resolution.
   function automatic bit bus_released(input int inst);
      logic [7:0] b;
      b = bus_of(inst);
      return (b === 8'hzz) || (b === 8'h00);
   endfunction

   function automatic int ws_of(input int inst);
      return (inst == 0) ? 0 : 3;
   endfunction

   // One CPU transaction. lat counts rising edges from the accepting edge to
   // the first cycle ack is seen; -1 means it never completed.
   task automatic txn(input int inst, input logic w, input logic [7:0] a, input logic [7:0] d,
                      input bit scramble, input logic [7:0] sa, input logic [7:0] sd,
                      output logic [7:0] rd, output int lat, output int we_c,
                      output int re_c, output int gap, output int bad);
      rd = 8'h00; lat = -1; we_c = 0; re_c = 0; gap = 0; bad = 0;
      req_s[inst] = 1'b1; wr_s[inst] = w; addr_s[inst] = a; wdata_s[inst] = d;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busy_s[inst]) break;
         gap++;
         if (!bus_released(inst)) bad++;
      end
      if (!busy_s[inst]) begin
         req_s[inst] = 1'b0;
         return;
      end
      for (int k = 0; k < 40; k++) begin
         if (scramble) begin
            req_s[inst] = 1'b1; wr_s[inst] = 1'b1; addr_s[inst] = sa; wdata_s[inst] = sd;
         end else begin
            req_s[inst] = 1'b0;
         end
         if (!cs_s[inst] || raddr_s[inst] !== a) bad++;
         if (w && bus_of(inst) !== d) bad++;
         if (we_s[inst]) we_c++;
         if (re_s[inst]) re_c++;
         if (ack_s[inst]) begin
            lat = k;
            rd = rdata_s[inst];
            break;
         end
         @(negedge clk);
      end
      req_s[inst] = 1'b0;
      if (lat >= 0 && w) ref_mem[inst][a] = d;
   endtask

   task automatic test_reset();
      #12;
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if ({busy_s[i], ack_s[i], cs_s[i], we_s[i], re_s[i]} !== 5'b0 || st_s[i] !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_ctrl inst%0d: busy/ack/cs/we/re=%b state=%0d, required 00000 idle",
                     i, {busy_s[i], ack_s[i], cs_s[i], we_s[i], re_s[i]}, st_s[i]);
         end
         n_vec++;
         if (raddr_s[i] !== 8'h00 || rdata_s[i] !== 8'h00) begin
            n_err++;
            $display("FAIL reset_regs inst%0d: ram_addr=%h rdata=%h, required 00 00", i, raddr_s[i], rdata_s[i]);
         end
         n_vec++;
         if (!bus_released(i)) begin
            n_err++;
            $display("FAIL reset_bus inst%0d: ram_data=%h, required released", i, bus_of(i));
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      logic [7:0] rd;
      int lat, we_c, re_c, gap, bad;
      txn(0, 1'b1, 8'h3C, 8'hA5, 1'b0, 8'h00, 8'h00, rd, lat, we_c, re_c, gap, bad);
      n_vec++;
      if (lat !== 2 || we_c !== 1 || re_c !== 0 || bad !== 0) begin
         n_err++;
         $display("FAIL write_3c: lat=%0d we=%0d re=%0d bad=%0d, required 2 1 0 0", lat, we_c, re_c, bad);
      end
      repeat (2) @(negedge clk);
      txn(0, 1'b0, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, we_c, re_c, gap, bad);
      n_vec++;
      if (rd !== 8'hA5 || lat !== 2 || we_c !== 0 || re_c !== 2 || bad !== 0) begin
         n_err++;
         $display("FAIL read_3c: rdata=%h lat=%0d we=%0d re=%0d bad=%0d, required a5 2 0 2 0",
                  rd, lat, we_c, re_c, bad);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rd;
      int lat, we_c, re_c, gap, bad;
      txn(0, 1'b1, 8'h3C, 8'hA5, 1'b0, 8'h00, 8'h00, rd, lat, we_c, re_c, gap, bad);
      // Next request is raised in the ack cycle, i.e. req effectively stays high.
      txn(0, 1'b0, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, we_c, re_c, gap, bad);
      n_vec++;
      if (gap < 1 || bad !== 0 || rd !== 8'hA5 || lat !== 2) begin
         n_err++;
         $display("FAIL b2b_read: idle_gap=%0d bad=%0d rdata=%h lat=%0d, required >=1 0 a5 2", gap, bad, rd, lat);
      end
   endtask

   task automatic test_wait_states();
      logic [7:0] rd, v;
      int lat, we_c, re_c, gap, bad;
      v = 8'($urandom_range(1, 255));
      txn(1, 1'b1, 8'h10, v, 1'b0, 8'h00, 8'h00, rd, lat, we_c, re_c, gap, bad);
      n_vec++;
      if (lat !== 5 || we_c !== 4 || re_c !== 0 || bad !== 0) begin
         n_err++;
         $display("FAIL ws3_write: lat=%0d we=%0d re=%0d bad=%0d, required 5 4 0 0", lat, we_c, re_c, bad);
      end
      repeat (2) @(negedge clk);
      n_vec++;
      if (raddr_s[1] !== 8'h10 || cs_s[1] !== 1'b0 || !bus_released(1)) begin
         n_err++;
         $display("FAIL ws3_idle_hold: ram_addr=%h cs=%b, required 10 0 with bus released", raddr_s[1], cs_s[1]);
      end
      txn(1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, we_c, re_c, gap, bad);
      n_vec++;
      if (rd !== v || lat !== 5 || we_c !== 0 || re_c !== 5 || bad !== 0) begin
         n_err++;
         $display("FAIL ws3_read: rdata=%h lat=%0d we=%0d re=%0d bad=%0d, required %h 5 0 5 0",
                  rd, lat, we_c, re_c, bad, v);
      end
   endtask

   task automatic test_busy_ignore();
      logic [7:0] rd;
      int lat, we_c, re_c, gap, bad;
      txn(0, 1'b1, 8'h77, 8'h11, 1'b0, 8'h00, 8'h00, rd, lat, we_c, re_c, gap, bad);
      txn(0, 1'b1, 8'h20, 8'h5A, 1'b1, 8'h77, 8'hEE, rd, lat, we_c, re_c, gap, bad);
      n_vec++;
      if (lat !== 2 || we_c !== 1 || bad !== 0) begin
         n_err++;
         $display("FAIL busy_write: lat=%0d we=%0d bad=%0d, required 2 1 0", lat, we_c, bad);
      end
      @(negedge clk);
      txn(0, 1'b0, 8'h77, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, we_c, re_c, gap, bad);
      n_vec++;
      if (rd !== 8'h11) begin
         n_err++;
         $display("FAIL busy_ignored_addr: rdata=%h, required 11", rd);
      end
      txn(0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, we_c, re_c, gap, bad);
      n_vec++;
      if (rd !== 8'h5A) begin
         n_err++;
         $display("FAIL busy_target_addr: rdata=%h, required 5a", rd);
      end
   endtask

   task automatic test_reset_mid_write();
      logic [7:0] rd;
      int lat, we_c, re_c, gap, bad, acks, wes;
      @(negedge clk);
      req_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 8'h55; wdata_s[0] = 8'h3C;
      @(negedge clk);
      req_s[0] = 1'b0;
      @(negedge clk);
      n_vec++;
      if (we_s[0] !== 1'b1 || busy_s[0] !== 1'b1) begin
         n_err++;
         $display("FAIL abort_precond: we=%b busy=%b, required 1 1", we_s[0], busy_s[0]);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({busy_s[0], ack_s[0], cs_s[0], we_s[0], re_s[0]} !== 5'b0 || !bus_released(0)) begin
         n_err++;
         $display("FAIL abort_drop: busy/ack/cs/we/re=%b ram_data=%h, required 00000 released",
                  {busy_s[0], ack_s[0], cs_s[0], we_s[0], re_s[0]}, bus_of(0));
      end
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0; wes = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ack_s[0]) acks++;
         if (we_s[0]) wes++;
      end
      n_vec++;
      if (acks !== 0 || wes !== 0) begin
         n_err++;
         $display("FAIL abort_after: acks=%0d we_cycles=%0d, required 0 0", acks, wes);
      end
      txn(0, 1'b0, 8'h55, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, we_c, re_c, gap, bad);
      n_vec++;
      if (rd !== ref_mem[0][8'h55]) begin
         n_err++;
         $display("FAIL abort_mem: rdata=%h, required %h", rd, ref_mem[0][8'h55]);
      end
   endtask

   task automatic test_random();
      logic [7:0] rd, a, d, exp_rd;
      logic w;
      bit sc;
      int inst, lat, we_c, re_c, gap, bad, ws;
      for (int n = 0; n < 1000; n++) begin
         inst = (n % 5 == 0) ? 1 : 0;
         ws = ws_of(inst);
         w = 1'($urandom_range(0, 1));
         a = 8'($urandom_range(0, 255));
         d = 8'($urandom_range(0, 255));
         sc = ($urandom_range(0, 7) == 0);
         exp_rd = ref_mem[inst][a];
         txn(inst, w, a, d, sc, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             rd, lat, we_c, re_c, gap, bad);
         n_vec++;
         if (lat !== 2 + ws || bad !== 0 || we_c !== (w ? 1 + ws : 0) || re_c !== (w ? 0 : 2 + ws)) begin
            n_err++;
            $display("FAIL rand_txn #%0d inst%0d wr=%b: lat=%0d bad=%0d we=%0d re=%0d, required lat %0d",
                     n, inst, w, lat, bad, we_c, re_c, 2 + ws);
         end
         if (!w) begin
            n_vec++;
            if (rd !== exp_rd) begin
               n_err++;
               $display("FAIL rand_read #%0d inst%0d addr=%h: rdata=%h, required %h", n, inst, a, rd, exp_rd);
            end
         end
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if (overlap_cnt !== 0 || idle_ctrl_cnt !== 0) begin
         n_err++;
         $display("FAIL strobe_rules: we&re cycles=%0d idle-strobe cycles=%0d, required 0 0",
                  overlap_cnt, idle_ctrl_cnt);
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         req_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 8'h00; wdata_s[i] = 8'h00;
      end
      test_reset();
      test_write_read();
      test_back_to_back();
      test_wait_states();
      test_busy_ignore();
      test_reset_mid_write();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
